// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage for the 16-bit pipelined MIPS subset. Owns the
// program counter and presents it to the combinational instruction memory.
// The returned word is captured into the IF/ID pipeline register. Stall and
// redirect requests from later stages are honoured. A count of issued
// instructions is kept for the board's debug display.
//
// Ports:
//   clock          in   system clock, rising-edge active
//   reset          in   synchronous, active-low reset
//   iaddr          out  instruction byte address (equals pc)
//   idata          in   instruction word for iaddr, same cycle
//   stall          in   hold the fetch stage this cycle
//   redirect       in   taken branch / jump resolved downstream
//   redirect_addr  in   redirect target byte address (bit 0 ignored)
//   if_instr       out  IF/ID instruction register
//   if_pc          out  byte address of if_instr
//   if_pc2         out  if_pc + 2 (branch offset / link base)
//   if_valid       out  IF/ID holds a real instruction
//   fetch_count    out  instructions issued into IF/ID, wraps mod 2^16
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] iaddr,
  input  logic [15:0] idata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc2,
  output logic        if_valid,
  output logic [15:0] fetch_count
);

  // Instructions are halfword aligned, so pc[0] is never set.
  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  logic [15:0] pc_q, pc_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] if_pc2_q, if_pc2_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] pc_plus2;

  // Sequential increment; 16-bit arithmetic so FFFE wraps to 0000.
  assign pc_plus2 = pc_q + 16'd2;

  // Redirect beats stall: a taken branch squashes whatever was held and
  // inserts a one-cycle bubble while the target is fetched.
  always_comb begin
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc2_d      = if_pc2_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;
    if (redirect) begin
      pc_d       = {redirect_addr[15:1], 1'b0};
      if_valid_d = 1'b0;
      if_instr_d = 16'h0000;
    end else if (!stall) begin
      if_instr_d    = idata;
      if_pc_d       = pc_q;
      if_pc2_d      = pc_plus2;
      if_valid_d    = 1'b1;
      pc_d          = pc_plus2;
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // Reset takes precedence over stall and redirect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q          <= RESET_PC_ALIGNED;
      if_instr_q    <= 16'h0000;
      if_pc_q       <= 16'h0000;
      if_pc2_q      <= 16'h0000;
      if_valid_q    <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc2_q      <= if_pc2_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign iaddr       = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc2      = if_pc2_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = fetch_count_q;

endmodule
